// File: rtl/gpio_cfg_loader_if.sv
// Bus bundle for gpio_cfg_loader: the PS GPIO input plus every active
// configuration output. The DUT attaches through the slave modport.
interface gpio_cfg_loader_if #(
  parameter int CFG_W  = 256,
  parameter int SEL_W  = 16,
  parameter int AVG_W  = 16,
  parameter int GPIO_W = 16
);
  logic [GPIO_W-1:0] gpio;
  logic [SEL_W-1:0]  sel;
  logic              mux_set;
  logic [CFG_W-1:0]  run_cycles;
  logic [CFG_W-1:0]  delay_cycles;
  logic [AVG_W-1:0]  adc_num_avg;
  logic [CFG_W-1:0]  adc_cycles;
  logic              trig_pulse;
  logic              pl_rst_out;

  modport master (
    output gpio,
    input  sel, mux_set, run_cycles, delay_cycles,
    input  adc_num_avg, adc_cycles, trig_pulse, pl_rst_out
  );

  modport slave (
    input  gpio,
    output sel, mux_set, run_cycles, delay_cycles,
    output adc_num_avg, adc_cycles, trig_pulse, pl_rst_out
  );
endinterface

// File: rtl/gpio_cfg_loader.sv
// Loads DAC/ADC configuration words bit-serially from PS GPIO into shadow
// registers and commits them on trigger. GPIO_CFG_SYNC_EN selects a 2-flop input synchronizer.
module gpio_cfg_loader #(
  parameter int CFG_W  = 256,
  parameter int SEL_W  = 16,
  parameter int AVG_W  = 16,
  parameter int GPIO_W = 16
) (
  input logic              clk,
  input logic              rst,
  gpio_cfg_loader_if.slave io_bus
);

  // Packed positions of the used gpio bits after the input stage.
  localparam int IN_W    = 9;
  localparam int I_SDATA = 0;  // gpio[0]
  localparam int I_SEL   = 1;  // gpio[2]
  localparam int I_RUN   = 2;  // gpio[3]
  localparam int I_MUX   = 3;  // gpio[4]
  localparam int I_PLRST = 4;  // gpio[5]
  localparam int I_TRIG  = 5;  // gpio[6]
  localparam int I_AVG   = 6;  // gpio[7]
  localparam int I_ADC   = 7;  // gpio[8]
  localparam int I_DLY   = 8;  // gpio[9]

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_ARMED_HIGH
  } state_t;

  logic [IN_W-1:0]     w_gpio_in;
  logic [GPIO_W-10:0]  w_unused_gpio;
  logic [IN_W-1:0]     r_sync;
  logic                r_sync_vld;
  logic [IN_W-1:0]     r_prev;
  logic                r_prev_vld;
  logic [IN_W-1:0]     w_rise;
  logic [1:0]          w_unused_rise;
  logic                w_sdata;
  logic                w_rst;

  assign w_gpio_in     = io_bus.gpio[9:2] == 8'h00 ? {8'h00, io_bus.gpio[0]}
                                                   : {io_bus.gpio[9:2], io_bus.gpio[0]};
  assign w_unused_gpio = {io_bus.gpio[GPIO_W-1:10], io_bus.gpio[1]};

  // ---------------------------------------------------------------------------
  // Input stage. The valid flags track pipeline fill after reset so that a bit
  // already high on release is never mistaken for a rising edge.
  // ---------------------------------------------------------------------------
`ifdef GPIO_CFG_SYNC_EN
  logic [IN_W-1:0] r_meta;
  logic            r_meta_vld;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta     <= '0;
      r_meta_vld <= 1'b0;
      r_sync     <= '0;
      r_sync_vld <= 1'b0;
    end else begin
      r_meta     <= w_gpio_in;
      r_meta_vld <= 1'b1;
      r_sync     <= r_meta;
      r_sync_vld <= r_meta_vld;
    end
  end
`else
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync     <= '0;
      r_sync_vld <= 1'b0;
    end else begin
      r_sync     <= w_gpio_in;
      r_sync_vld <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
    end else begin
      r_prev     <= r_sync;
      r_prev_vld <= r_sync_vld;
    end
  end

  assign w_rise        = r_sync & ~r_prev & {IN_W{r_prev_vld}};
  assign w_unused_rise = {w_rise[I_SDATA], w_rise[I_PLRST]};
  assign w_sdata       = r_sync[I_SDATA];

  // pl_rst acts exactly like rst on everything downstream of the input stage.
  assign w_rst = rst | r_sync[I_PLRST];

  // ---------------------------------------------------------------------------
  // Shadow shift registers, MSB-first. All share the same sdata sample, so
  // coincident serial clocks shift the same bit into each.
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] r_sel_sh;
  logic             r_mux_sh;
  logic [CFG_W-1:0] r_run_sh;
  logic [CFG_W-1:0] r_dly_sh;
  logic [AVG_W-1:0] r_avg_sh;
  logic [CFG_W-1:0] r_adc_sh;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_sel_sh <= '0;
      r_mux_sh <= 1'b0;
      r_run_sh <= '0;
      r_dly_sh <= '0;
      r_avg_sh <= '0;
      r_adc_sh <= '0;
    end else begin
      if (w_rise[I_SEL]) r_sel_sh <= {r_sel_sh[SEL_W-2:0], w_sdata};
      if (w_rise[I_MUX]) r_mux_sh <= w_sdata;
      if (w_rise[I_RUN]) r_run_sh <= {r_run_sh[CFG_W-2:0], w_sdata};
      if (w_rise[I_DLY]) r_dly_sh <= {r_dly_sh[CFG_W-2:0], w_sdata};
      if (w_rise[I_AVG]) r_avg_sh <= {r_avg_sh[AVG_W-2:0], w_sdata};
      if (w_rise[I_ADC]) r_adc_sh <= {r_adc_sh[CFG_W-2:0], w_sdata};
    end
  end

  // ---------------------------------------------------------------------------
  // Commit control FSM
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   w_commit;

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise[I_TRIG]) begin
          w_commit    = 1'b1;
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT:     w_state_nxt = r_sync[I_TRIG] ? S_ARMED_HIGH : S_IDLE;
      S_ARMED_HIGH: if (!r_sync[I_TRIG]) w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Active registers: loaded with the pre-shift shadow values on commit.
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] r_sel;
  logic             r_mux;
  logic [CFG_W-1:0] r_run;
  logic [CFG_W-1:0] r_dly;
  logic [AVG_W-1:0] r_avg;
  logic [CFG_W-1:0] r_adc;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_sel <= '0;
      r_mux <= 1'b0;
      r_run <= '0;
      r_dly <= '0;
      r_avg <= '0;
      r_adc <= '0;
    end else if (w_commit) begin
      r_sel <= r_sel_sh;
      r_mux <= r_mux_sh;
      r_run <= r_run_sh;
      r_dly <= r_dly_sh;
      r_avg <= r_avg_sh;
      r_adc <= r_adc_sh;
    end
  end

  assign io_bus.sel          = r_sel;
  assign io_bus.mux_set      = r_mux;
  assign io_bus.run_cycles   = r_run;
  assign io_bus.delay_cycles = r_dly;
  assign io_bus.adc_num_avg  = r_avg;
  assign io_bus.adc_cycles   = r_adc;
  assign io_bus.trig_pulse   = (r_state == S_COMMIT);
  assign io_bus.pl_rst_out   = r_sync[I_PLRST];

endmodule

// File: doc/gpio_cfg_loader.md
GPIO_CFG_LOADER -- requirements
Module: gpio_cfg_loader

Interface
REQ-001 Parameter CFG_W, default 256: width of run, delay and ADC cycle-count registers.
REQ-002 Parameter SEL_W, default 16: width of the one-hot channel-select register.
REQ-003 Parameter AVG_W, default 16: width of the ADC average-count register.
REQ-004 Parameter GPIO_W, default 16: width of the PS GPIO bus.
REQ-005 clk  in  1  fabric clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 gpio  in  GPIO_W  PS GPIO bus, asynchronous to clk. Bit 0 sdata, 2 sel_clk, 3 cycle_count_clk, 4 mux_set_clk, 5 pl_rst, 6 trigger_line, 7 adc_num_avg_clk, 8 adc_num_cycle_count_clk, 9 delay_cycle_clk. Bits 1, 10 and above are ignored by this block.
REQ-008 sel  out  SEL_W  active channel-select register.
REQ-009 mux_set  out  1  active mux-state bit.
REQ-010 run_cycles  out  CFG_W  active DAC run-cycle count.
REQ-011 delay_cycles  out  CFG_W  active DAC trigger-delay count.
REQ-012 adc_num_avg  out  AVG_W  active ADC average count.
REQ-013 adc_cycles  out  CFG_W  active ADC run-cycle count.
REQ-014 trig_pulse  out  1  one-cycle strobe issued on each commit.
REQ-015 pl_rst_out  out  1  synchronized pl_rst level.

Function
REQ-016 Every used gpio bit passes through the input stage (REQ-033). Edge detection then compares the stage output with a one-cycle-delayed copy; a rising edge is (now=1, prev=0).
REQ-017 Each of the six serial clocks (bits 2, 3, 4, 7, 8, 9) owns a shadow register of its output's width.
- On a rising edge of a serial clock, its shadow shifts MSB-first: shadow <= {shadow[W-2:0], sdata}.
- sdata is taken from the same input-stage cycle as the edge.
REQ-018 Simultaneous rising edges on several serial clocks shall shift each affected shadow with the same sdata bit.
REQ-019 Shifting more bits than the width discards the oldest bits; there is no overflow flag and no wrap error.
REQ-020 Shadow registers never drive outputs directly. Active outputs change only on commit.
REQ-021 Commit occurs on a rising edge of trigger_line:
- every active register <= its shadow value in the same clock;
- trig_pulse is high for exactly that one following cycle.
REQ-022 If a serial-clock edge and a trigger edge coincide, commit takes the pre-shift shadow value. The shift still updates the shadow.
REQ-023 A trigger held high produces exactly one commit and one trig_pulse. A new commit requires trigger_line to go low and then high again.
REQ-024 Control FSM states:
- IDLE: no trigger high.
- COMMIT: one cycle, trig_pulse=1.
- ARMED_HIGH: trigger still high.
REQ-025 FSM transitions:
- IDLE->COMMIT on trigger rising edge.
- COMMIT->ARMED_HIGH if trigger is high, else ->IDLE.
- ARMED_HIGH->IDLE when trigger is low.
REQ-026 pl_rst_out equals the synchronized pl_rst level. While it is high, all shadows, active registers and the FSM are held in reset, exactly as for rst.
REQ-027 No combinational path from gpio to any output.

Reset
REQ-028 When rst=1 at a clk edge, all shadows and all active outputs are cleared to 0, trig_pulse is 0, and the FSM enters IDLE.
REQ-029 Reset also clears the input stage and the edge-detect history, so a gpio bit already high on release does not register as a rising edge.
REQ-030 Reset asserted mid-shift discards partial shadow contents. There is no resume.
REQ-031 pl_rst_out resets to 0.

Configuration
REQ-032 Macro GPIO_CFG_SYNC_EN selects the input stage.
REQ-033 With GPIO_CFG_SYNC_EN defined, the input stage is a 2-flop synchronizer. A gpio change reaches a shadow shift or commit on the 3rd clk edge after it is applied.
REQ-034 Without GPIO_CFG_SYNC_EN, the input stage is a single register, giving 2-edge latency. This is for benches and synchronous-source use only.

Verification
REQ-035 Reset: assert rst for 2 cycles with all gpio high, then release -> all outputs 0, trig_pulse stays 0, and no shift occurs.
REQ-036 Load and commit:
- stimulus: shift 16 bits 0x0004 (MSB-first) on sel_clk, then pulse trigger_line;
- response: sel stays 0 until commit, then becomes 0x0004 with trig_pulse high for exactly 1 cycle at the expected latency.
REQ-037 Full-width and overflow: shift 256 ones then 4 zeros on cycle_count_clk, then trigger -> run_cycles = all-ones except 4 LSBs = 0.
REQ-038 Coincident edges: raise delay_cycle_clk and trigger on the same clk with delay shadow = 5 and sdata=1 -> delay_cycles=5 after commit, shadow=11.
REQ-039 Held trigger: hold trigger high for 20 cycles -> exactly one trig_pulse; a second low-high cycle -> a second pulse.
REQ-040 pl_rst mid-load: after 8 of 16 bits on adc_num_avg_clk, assert pl_rst -> pl_rst_out rises after the input-stage latency, all registers clear, and a later commit outputs 0.
